// File: rtl/sram_axi_bridge.sv
// SRAM-like to AXI3 bridge: instruction and data request ports share one read
// FSM (one outstanding read), data stores use a separate write FSM. The data
// port keeps at most one transaction in flight, so loads never pass stores.
module sram_axi_bridge #(
    parameter int unsigned DATA_PRIO = 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [1:0] {RdIdle, RdAr, RdR} rd_state_e;
    typedef enum logic [1:0] {WrIdle, WrAwW, WrB} wr_state_e;

    rd_state_e   r_rd_state, w_rd_state_nxt;
    wr_state_e   w_wr_state_nxt, r_wr_state;

    logic [31:0] r_rd_addr;
    logic [1:0]  r_rd_size;
    logic        r_rd_id;

    logic [31:0] r_wr_addr;
    logic [1:0]  r_wr_size;
    logic [3:0]  r_wr_strb;
    logic [31:0] r_wr_data;
    logic        r_aw_done;
    logic        r_w_done;

    logic        w_rd_idle;
    logic        w_wr_idle;
    logic        w_drd_cand;
    logic        w_inst_cand;
    logic        w_drd_acc;
    logic        w_dwr_acc;
    logic        w_inst_acc;
    logic        w_rd_done;
    logic        w_b_done;

    // Inputs the bridge deliberately ignores (read-only inst port, rid/rresp/rlast/bid/bresp).
    logic w_unused;
    assign w_unused = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                        rid, rresp, rlast, bid, bresp};

    // Acceptance: combinational from req and FSM state, forced low in reset.
    always_comb begin
        w_rd_idle   = (r_rd_state == RdIdle);
        w_wr_idle   = (r_wr_state == WrIdle);
        // Read FSM idle implies no data read outstanding; write must be idle too.
        w_drd_cand  = data_sram_req && !data_sram_wr && w_rd_idle && w_wr_idle && !reset;
        w_inst_cand = inst_sram_req && w_rd_idle && !reset;
        if (DATA_PRIO != 0) begin
            w_drd_acc  = w_drd_cand;
            w_inst_acc = w_inst_cand && !w_drd_cand;
        end else begin
            w_drd_acc  = w_drd_cand && !w_inst_cand;
            w_inst_acc = w_inst_cand;
        end
        w_dwr_acc   = data_sram_req && data_sram_wr && w_wr_idle && !reset
                      && !(!w_rd_idle && r_rd_id);
        w_rd_done   = (r_rd_state == RdR) && rvalid && !reset;
        w_b_done    = (r_wr_state == WrB) && bvalid && !reset;
    end

    // Read FSM next-state.
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        unique case (r_rd_state)
            RdIdle:  if (w_drd_acc || w_inst_acc) w_rd_state_nxt = RdAr;
            RdAr:    if (arready) w_rd_state_nxt = RdR;
            RdR:     if (rvalid) w_rd_state_nxt = RdIdle;
            default: w_rd_state_nxt = RdIdle;
        endcase
    end

    // Read FSM state register and latched AR payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_state <= RdIdle;
            r_rd_addr  <= '0;
            r_rd_size  <= '0;
            r_rd_id    <= 1'b0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            if (w_drd_acc) begin
                r_rd_addr <= data_sram_addr;
                r_rd_size <= data_sram_size;
                r_rd_id   <= 1'b1;
            end else if (w_inst_acc) begin
                r_rd_addr <= inst_sram_addr;
                r_rd_size <= inst_sram_size;
                r_rd_id   <= 1'b0;
            end
        end
    end

    // Write FSM next-state: leave AW/W once both handshakes are done (past or now).
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        unique case (r_wr_state)
            WrIdle:  if (w_dwr_acc) w_wr_state_nxt = WrAwW;
            WrAwW:   if ((r_aw_done || awready) && (r_w_done || wready)) w_wr_state_nxt = WrB;
            WrB:     if (bvalid) w_wr_state_nxt = WrIdle;
            default: w_wr_state_nxt = WrIdle;
        endcase
    end

    // Write FSM state register, latched store payload and per-channel done flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_state <= WrIdle;
            r_wr_addr  <= '0;
            r_wr_size  <= '0;
            r_wr_strb  <= '0;
            r_wr_data  <= '0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            if (w_dwr_acc) begin
                r_wr_addr <= data_sram_addr;
                r_wr_size <= data_sram_size;
                r_wr_strb <= data_sram_wstrb;
                r_wr_data <= data_sram_wdata;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                if (awvalid && awready) r_aw_done <= 1'b1;
                if (wvalid && wready)   r_w_done  <= 1'b1;
            end
        end
    end

    // Output decode: AXI channels from state, SRAM handshakes from acceptance/completion.
    always_comb begin
        inst_sram_addr_ok = w_inst_acc;
        data_sram_addr_ok = w_drd_acc || w_dwr_acc;
        inst_sram_data_ok = w_rd_done && !r_rd_id;
        data_sram_data_ok = (w_rd_done && r_rd_id) || w_b_done;
        inst_sram_rdata   = rdata;
        data_sram_rdata   = rdata;

        arid    = {3'b000, r_rd_id};
        araddr  = r_rd_addr;
        arsize  = {1'b0, r_rd_size};
        arlen   = 8'd0;
        arburst = 2'd1;
        arlock  = 2'd0;
        arcache = 4'd0;
        arprot  = 3'd0;
        arvalid = (r_rd_state == RdAr);
        rready  = (r_rd_state == RdR);

        awid    = 4'd1;
        awaddr  = r_wr_addr;
        awsize  = {1'b0, r_wr_size};
        awlen   = 8'd0;
        awburst = 2'd1;
        awlock  = 2'd0;
        awcache = 4'd0;
        awprot  = 3'd0;
        awvalid = (r_wr_state == WrAwW) && !r_aw_done;

        wid     = 4'd1;
        wdata   = r_wr_data;
        wstrb   = r_wr_strb;
        wlast   = 1'b1;
        wvalid  = (r_wr_state == WrAwW) && !r_w_done;

        bready  = (r_wr_state == WrB);
    end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: a transaction-level model predicts every
// handshake output each cycle; directed checks pin the model with literals.
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst, awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid, awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] ar_ids[$];

    sram_axi_bridge dut (
        .clk(clk), .reset(reset),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
        .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
        .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
        .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: one pending read record, one pending store record.
    bit          m_rd_busy, m_ar_sent, m_rd_id;
    logic [31:0] m_rd_addr;
    logic [1:0]  m_rd_size;
    bit          m_wr_busy, m_aw_done, m_w_done;
    logic [31:0] m_wr_addr, m_wr_data;
    logic [1:0]  m_wr_size;
    logic [3:0]  m_wr_strb;

    always @(negedge clk) begin
        bit d_cand, d_rd, d_wr, i_rd, e_arv, e_rr, e_awv, e_wv, e_br, rd_done, b_done;
        d_cand  = data_sram_req && !data_sram_wr && !m_rd_busy && !m_wr_busy && !reset;
        d_rd    = d_cand;
        i_rd    = inst_sram_req && !m_rd_busy && !d_cand && !reset;
        d_wr    = data_sram_req && data_sram_wr && !m_wr_busy && !(m_rd_busy && m_rd_id)
                  && !reset;
        e_arv   = m_rd_busy && !m_ar_sent;
        e_rr    = m_rd_busy && m_ar_sent;
        e_awv   = m_wr_busy && !m_aw_done;
        e_wv    = m_wr_busy && !m_w_done;
        e_br    = m_wr_busy && m_aw_done && m_w_done;
        rd_done = e_rr && rvalid && !reset;
        b_done  = e_br && bvalid && !reset;

        check("model_sram_hs",
              {28'd0, inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok},
              {28'd0, i_rd, d_rd || d_wr, rd_done && !m_rd_id, (rd_done && m_rd_id) || b_done});
        if (!reset) begin
            check("model_axi_hs", {27'd0, arvalid, rready, awvalid, wvalid, bready},
                  {27'd0, e_arv, e_rr, e_awv, e_wv, e_br});
            if (e_arv)
                check("model_ar_payload", araddr ^ {25'd0, arsize, arid},
                      m_rd_addr ^ {25'd0, 1'b0, m_rd_size, 3'd0, m_rd_id});
            if (e_awv) check("model_awaddr", awaddr, m_wr_addr);
            if (e_wv)  check("model_wdata", wdata, m_wr_data);
            if (e_awv || e_wv)
                check("model_w_ctl", {21'd0, awsize, wstrb, awid}, {21'd0, 1'b0, m_wr_size,
                      m_wr_strb, 4'd1});
            if (rd_done)
                check("model_rdata", m_rd_id ? data_sram_rdata : inst_sram_rdata, rdata);
            if (arvalid && arready) ar_ids.push_back(arid);
        end

        if (reset) begin
            m_rd_busy = 0; m_ar_sent = 0; m_wr_busy = 0; m_aw_done = 0; m_w_done = 0;
        end else begin
            if (rd_done) m_rd_busy = 0;
            else if (e_arv && arready) m_ar_sent = 1;
            if (d_rd || i_rd) begin
                m_rd_busy = 1; m_ar_sent = 0; m_rd_id = d_rd;
                m_rd_addr = d_rd ? data_sram_addr : inst_sram_addr;
                m_rd_size = d_rd ? data_sram_size : inst_sram_size;
            end
            if (b_done) m_wr_busy = 0;
            if (e_awv && awready) m_aw_done = 1;
            if (e_wv && wready) m_w_done = 1;
            if (d_wr) begin
                m_wr_busy = 1; m_aw_done = 0; m_w_done = 0;
                m_wr_addr = data_sram_addr; m_wr_data = data_sram_wdata;
                m_wr_size = data_sram_size; m_wr_strb = data_sram_wstrb;
            end
        end
    end

    // Complete whatever read is pending; bounded wait on a data_ok.
    task automatic serve_read(input logic [31:0] d);
        bit seen = 0;
        arready = 1'b1; rdata = d; rvalid = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (inst_sram_data_ok || data_sram_data_ok) begin
                seen = 1;
                check("serve_rdata", inst_sram_data_ok ? inst_sram_rdata : data_sram_rdata, d);
            end
            tick();
        end
        if (!seen) check("serve_read_timeout", 32'd0, 32'd1);
        rvalid = 1'b0; arready = 1'b0;
    endtask

    task automatic set_inst(input logic req, input logic [31:0] addr);
        inst_sram_req = req; inst_sram_addr = addr; inst_sram_size = 2'd2;
    endtask

    task automatic set_data(input logic req, input logic wr, input logic [1:0] size,
                            input logic [31:0] addr, input logic [3:0] strb,
                            input logic [31:0] wd);
        data_sram_req = req; data_sram_wr = wr; data_sram_size = size;
        data_sram_addr = addr; data_sram_wstrb = strb; data_sram_wdata = wd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        inst_sram_wr = 1'b0; inst_sram_wstrb = 4'hf; inst_sram_wdata = 32'hffff_ffff;
        set_inst(1'b1, 32'h1c00_0000);
        set_data(1'b1, 1'b0, 2'd2, 32'h0000_1000, 4'h0, 32'h0);
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
        awready = 0; wready = 0; bid = 1; bresp = 0; bvalid = 0;

        // Reset: addr_ok forced low even with requests present.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_addr_ok", {30'd0, inst_sram_addr_ok, data_sram_addr_ok}, 32'd0);
            tick();
        end
        set_inst(1'b0, 32'h0);
        set_data(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("reset_valids", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
        check("ar_ties", {13'd0, arlen, arburst, arlock, arcache, arprot},
              {13'd0, 8'd0, 2'd1, 2'd0, 4'd0, 3'd0});
        check("aw_ties", {12'd0, awlen, awburst, awlock, awcache, awprot, wlast},
              {12'd0, 8'd0, 2'd1, 2'd0, 4'd0, 3'd0, 1'b1});
        tick();

        // Instruction read, zero wait.
        set_inst(1'b1, 32'h1c00_0000); arready = 1'b1;
        @(negedge clk); check("t1_addr_ok", inst_sram_addr_ok, 1);
        tick(); set_inst(1'b0, 32'h0);
        @(negedge clk);
        check("t1_arvalid", arvalid, 1);
        check("t1_araddr", araddr, 32'h1c00_0000);
        check("t1_arid_size", {arid, 1'b0, arsize}, {4'd0, 4'd2});
        tick(); rvalid = 1'b1; rdata = 32'h0280_0c0c;
        @(negedge clk);
        check("t1_data_ok", inst_sram_data_ok, 1);
        check("t1_rdata", inst_sram_rdata, 32'h0280_0c0c);
        tick(); rvalid = 1'b0;
        @(negedge clk); check("t1_pulse", inst_sram_data_ok, 0);
        tick();

        // Simultaneous reads: data wins, inst waits until the data read returns.
        ar_ids.delete();
        set_inst(1'b1, 32'h1c00_0004);
        set_data(1'b1, 1'b0, 2'd2, 32'h0000_1000, 4'h0, 32'h0);
        @(negedge clk);
        check("t2_addr_ok", {30'd0, inst_sram_addr_ok, data_sram_addr_ok}, 32'd1);
        tick(); set_data(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
        @(negedge clk); check("t2_inst_blocked", inst_sram_addr_ok, 0);
        tick(); rvalid = 1'b1; rdata = 32'h1122_3344;
        @(negedge clk);
        check("t2_data_ok", data_sram_data_ok, 1);
        check("t2_data_rdata", data_sram_rdata, 32'h1122_3344);
        check("t2_inst_still_blocked", inst_sram_addr_ok, 0);
        tick(); rvalid = 1'b0;
        @(negedge clk); check("t2_inst_accept", inst_sram_addr_ok, 1);
        tick(); set_inst(1'b0, 32'h0);
        serve_read(32'h5566_7788);
        check("t2_arid_count", ar_ids.size(), 2);
        if (ar_ids.size() == 2) check("t2_arid_order", {ar_ids[0], ar_ids[1]}, 8'h10);

        // Byte store, W handshake 3 cycles after AW.
        arready = 1'b0; awready = 1'b1; wready = 1'b0;
        set_data(1'b1, 1'b1, 2'd0, 32'h1c08_00a3, 4'b1000, 32'hab00_0000);
        @(negedge clk); check("t3_addr_ok", data_sram_addr_ok, 1);
        tick(); set_data(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        check("t3_aw_w_valid", {awvalid, wvalid}, 2'b11);
        check("t3_awaddr", awaddr, 32'h1c08_00a3);
        check("t3_wstrb_data", {wstrb, awsize, wdata[31:24]}, {4'b1000, 3'd0, 8'hab});
        tick(); awready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t3_w_held", {awvalid, wvalid, bready}, 3'b010);
            tick();
        end
        wready = 1'b1;
        @(negedge clk); check("t3_w_last_cycle", {awvalid, wvalid, bready}, 3'b010);
        tick(); wready = 1'b0;
        @(negedge clk); check("t3_bready", {awvalid, wvalid, bready, data_sram_data_ok}, 4'b0010);
        tick(); bvalid = 1'b1;
        @(negedge clk); check("t3_data_ok", data_sram_data_ok, 1);
        tick(); bvalid = 1'b0;
        @(negedge clk); check("t3_pulse", {bready, data_sram_data_ok}, 2'b00);
        tick();

        // Load after store: load held off, inst read proceeds meanwhile.
        awready = 1'b1; wready = 1'b1;
        set_data(1'b1, 1'b1, 2'd2, 32'h0000_2000, 4'hf, 32'h0000_0055);
        @(negedge clk); check("t4_store_ok", data_sram_addr_ok, 1);
        tick();
        set_data(1'b1, 1'b0, 2'd2, 32'h0000_2000, 4'h0, 32'h0);
        set_inst(1'b1, 32'h1c00_0010); arready = 1'b1;
        @(negedge clk);
        check("t4_window", {30'd0, inst_sram_addr_ok, data_sram_addr_ok}, 32'd2);
        tick(); set_inst(1'b0, 32'h0); awready = 1'b0; wready = 1'b0;
        @(negedge clk); check("t4_load_wait", data_sram_addr_ok, 0);
        tick(); bvalid = 1'b1; rvalid = 1'b1; rdata = 32'h0000_0013;
        @(negedge clk);
        check("t4_both_done", {30'd0, inst_sram_data_ok, data_sram_data_ok}, 32'd3);
        check("t4_load_still_wait", data_sram_addr_ok, 0);
        tick(); bvalid = 1'b0; rvalid = 1'b0;
        @(negedge clk); check("t4_load_accept", data_sram_addr_ok, 1);
        tick(); set_data(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
        serve_read(32'h0000_0055);

        // AR backpressure for 5 cycles.
        arready = 1'b0;
        set_inst(1'b1, 32'h1c00_0020);
        @(negedge clk); check("t5_addr_ok", inst_sram_addr_ok, 1);
        tick(); set_inst(1'b0, 32'h0);
        set_data(1'b1, 1'b0, 2'd2, 32'h0000_3000, 4'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_ar_stable", {araddr[30:0], arvalid}, {31'h1c00_0020, 1'b1});
            check("t5_quiet", {arid, inst_sram_data_ok, data_sram_addr_ok}, 6'd0);
            tick();
        end
        set_data(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
        serve_read(32'hcafe_f00d);

        // Reset while waiting in the R phase.
        set_inst(1'b1, 32'h1c00_0030); arready = 1'b1;
        tick(); set_inst(1'b0, 32'h0);
        tick(); arready = 1'b0;
        @(negedge clk); check("t6_in_r", rready, 1);
        tick(); reset = 1'b1; set_inst(1'b1, 32'h1c00_0040);
        @(negedge clk); check("t6_reset_addr_ok", inst_sram_addr_ok, 0);
        tick();
        @(negedge clk);
        check("t6_cleared", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
        check("t6_reset_addr_ok2", inst_sram_addr_ok, 0);
        tick(); reset = 1'b0;
        @(negedge clk); check("t6_after_accept", inst_sram_addr_ok, 1);
        tick(); set_inst(1'b0, 32'h0);
        serve_read(32'hdead_beef);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
